// File: rtl/pc_next_unit.sv
// Next-PC unit with main-control decode: drives the incrementer, branch-target adder and PC register.
// Control outputs are decoded combinationally from OpCode and do not depend on clock or reset.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  OpCode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [15:0] Address,
    input  logic        Zero,
    output logic [31:0] PresentState,
    output logic        RegDst,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [1:0]  ALUOp
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [31:0] out4;
    logic [31:0] offset;
    logic [31:0] branch_target;
    logic        pc_src;
    logic [31:0] next_state;

    // Main control decode; anything not recognised behaves as a no-op.
    always_comb begin
        RegDst   = 1'b0;
        Branch   = 1'b0;
        MemRead  = 1'b0;
        MemtoReg = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        ALUOp    = 2'b00;
        case (OpCode)
            OP_RTYPE: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            OP_LW: begin
                ALUSrc   = 1'b1;
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                MemRead  = 1'b1;
            end
            OP_SW: begin
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            OP_BEQ: begin
                Branch = 1'b1;
                ALUOp  = 2'b01;
            end
            default: ;
        endcase
    end

    // The word offset is sign-extended before scaling so backward branches wrap correctly.
    assign out4          = A + B;
    assign offset        = {{14{Address[15]}}, Address, 2'b00};
    assign branch_target = out4 + offset;
    assign pc_src        = Branch & Zero;
    assign next_state    = pc_src ? branch_target : out4;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            PresentState <= RESET_PC;
        else
            PresentState <= next_state;
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: table-driven vectors with a PC scoreboard,
// hand-written reset sequences and a batch of random vectors against a reference model.
module tb_pc_next_unit;

    logic        Clk;
    logic        Reset;
    logic [5:0]  OpCode;
    logic [31:0] A;
    logic [31:0] B;
    logic [15:0] Address;
    logic        Zero;
    logic [31:0] PresentState;
    logic        RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic [8:0]  ctrlBus;

    int testsRun    = 0;
    int testsFailed = 0;
    logic [31:0] pcQueue[$];

    // Control bundle order: RegDst Branch MemRead MemtoReg MemWrite ALUSrc RegWrite ALUOp[1:0]
    localparam logic [8:0] C_R    = 9'b1_0_0_0_0_0_1_10;
    localparam logic [8:0] C_LW   = 9'b0_0_1_1_0_1_1_00;
    localparam logic [8:0] C_SW   = 9'b0_0_0_0_1_1_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_1_0_0_0_0_0_01;
    localparam logic [8:0] C_NONE = 9'b0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] addr;
        logic        zero;
        logic [8:0]  expCtrl;
        logic [31:0] expPc;
    } vec_t;

    vec_t vecs[$];

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .A(A), .B(B),
        .Address(Address), .Zero(Zero), .PresentState(PresentState),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp)
    );

    assign ctrlBus = {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [8:0] refCtrl(input logic [5:0] op);
        case (op)
            6'h00:   return C_R;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            default: return C_NONE;
        endcase
    endfunction

    function automatic logic [31:0] refPc(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [15:0] addr,
                                          input logic z);
        logic signed [31:0] wordOff;
        logic [31:0] seq;
        seq     = a + b;
        wordOff = 32'(signed'(addr));
        if (op == 6'h04 && z)
            return seq + 32'(wordOff * 4);
        return seq;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Drives one vector at the falling edge, checks decode, then scores the PC after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] expPc;
        @(negedge Clk);
        OpCode  = v.op;
        A       = v.a;
        B       = v.b;
        Address = v.addr;
        Zero    = v.zero;
        #1;
        checkOutput({v.name, " ctrl"}, 32'(ctrlBus), 32'(v.expCtrl));
        pcQueue.push_back(v.expPc);
        @(posedge Clk);
        #1;
        if (pcQueue.size() == 0) begin
            checkOutput({v.name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            expPc = pcQueue.pop_front();
            checkOutput({v.name, " pc"}, PresentState, expPc);
        end
    endtask

    initial begin
        vec_t v;
        logic [5:0] opSet[5];

        vecs.push_back('{"rtype",      6'h00, 32'h100,        32'd4,        16'h0000, 1'b1, C_R,    32'h104});
        vecs.push_back('{"beq_fwd",    6'h04, 32'h100,        32'd4,        16'h0003, 1'b1, C_BEQ,  32'h110});
        vecs.push_back('{"beq_back",   6'h04, 32'h100,        32'd4,        16'hFFFE, 1'b1, C_BEQ,  32'h0FC});
        vecs.push_back('{"beq_nt",     6'h04, 32'h100,        32'd4,        16'h0003, 1'b0, C_BEQ,  32'h104});
        vecs.push_back('{"lw",         6'h23, 32'h100,        32'd4,        16'h0003, 1'b1, C_LW,   32'h104});
        vecs.push_back('{"sw",         6'h2B, 32'h100,        32'd4,        16'h0003, 1'b1, C_SW,   32'h104});
        vecs.push_back('{"op3f",       6'h3F, 32'h100,        32'd4,        16'h0003, 1'b1, C_NONE, 32'h104});
        vecs.push_back('{"wrap",       6'h00, 32'hFFFF_FFFC,  32'd4,        16'h0000, 1'b0, C_R,    32'h0});
        vecs.push_back('{"beq_minoff", 6'h04, 32'h0010_0000,  32'd4,        16'h8000, 1'b1, C_BEQ,  32'h000E_0004});
        vecs.push_back('{"beq_maxoff", 6'h04, 32'h1000,       32'd4,        16'h7FFF, 1'b1, C_BEQ,  32'h0002_1000});
        vecs.push_back('{"rtype_add",  6'h00, 32'h1234_5678,  32'h1111_1111, 16'hFFFF, 1'b0, C_R,   32'h2345_6789});
        vecs.push_back('{"op05",       6'h05, 32'h200,        32'd4,        16'h0003, 1'b1, C_NONE, 32'h204});
        vecs.push_back('{"beq_wrap",   6'h04, 32'hFFFF_FFF0,  32'd4,        16'h0004, 1'b1, C_BEQ,  32'h4});

        // Reset asserted before any clock edge: PC is cleared at once and decode still works.
        Reset   = 1'b1;
        OpCode  = 6'h00;
        A       = 32'h100;
        B       = 32'd4;
        Address = 16'h0;
        Zero    = 1'b0;
        #1;
        checkOutput("reset_pc", PresentState, 32'h0);
        checkOutput("reset_ctrl", 32'(ctrlBus), 32'(C_R));
        @(posedge Clk);
        #1;
        checkOutput("reset_hold", PresentState, 32'h0);
        @(negedge Clk);
        Reset = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Mid-cycle reset overrides the pending update, then the first edge after release loads NextState.
        v = '{"pre_reset", 6'h00, 32'h100, 32'd4, 16'h0, 1'b0, C_R, 32'h104};
        applyStimulus(v);
        @(negedge Clk);
        OpCode = 6'h23;
        Reset  = 1'b1;
        #1;
        checkOutput("midreset_pc", PresentState, 32'h0);
        checkOutput("midreset_ctrl", 32'(ctrlBus), 32'(C_LW));
        @(posedge Clk);
        #1;
        checkOutput("midreset_hold", PresentState, 32'h0);
        Reset = 1'b0;
        v = '{"post_reset", 6'h04, 32'h40, 32'd4, 16'h0002, 1'b1, C_BEQ, 32'h4C};
        applyStimulus(v);

        // Random vectors against the reference model.
        opSet = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h3F};
        for (int i = 0; i < 24; i++) begin
            v.name = "rand";
            v.op   = (i % 6 == 5) ? 6'($urandom_range(0, 63)) : opSet[$urandom_range(0, 3)];
            v.a    = $urandom;
            v.b    = (i % 2 == 0) ? 32'd4 : $urandom;
            v.addr = 16'($urandom);
            v.zero = 1'($urandom);
            v.expCtrl = refCtrl(v.op);
            v.expPc   = refPc(v.op, v.a, v.b, v.addr, v.zero);
            applyStimulus(v);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
